axi4lite_reg_slave: RTL and testbench

//  AXI4-lite slave register bank attached to one m_axi_* port of axi4lite_interconnect (downstream stage).

---
 rtl/axi4lite_pkg.sv | 23 ++
 rtl/axi4lite_regfile_core.sv | 49 ++++
 rtl/axi4lite_reg_slave.sv | 158 +++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-lite response codes, word types, FSM state encodings and the byte-strobe merge.
// Types and one function only, so there is no latency or backpressure.
package axi4lite_pkg;

  typedef logic [1:0]  axi_resp_t;
  typedef logic [31:0] axi_word_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic axi_word_t strb_merge(input axi_word_t old_w, input axi_word_t new_w,
                                           input logic [3:0] strb);
    axi_word_t m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4lite_regfile_core.sv
// Register array with byte-strobe writes, a read-only ID slot and a combinational read port.
// Writes land on the clock edge and the strobe pulse follows in the next cycle; there is no backpressure.
module axi4lite_regfile_core
  import axi4lite_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter axi_word_t   ID_VALUE = 32'hA41C_0001
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_we,
  input  logic [$clog2(NUM_REGS)-1:0]   i_widx,
  input  axi_word_t                     i_wdata,
  input  logic [3:0]                    i_wstrb,
  input  logic [$clog2(NUM_REGS)-1:0]   i_ridx,
  output axi_word_t                     o_rdata,
  output logic [NUM_REGS*32-1:0]        o_regs,
  output logic [NUM_REGS-1:0]           o_wr_stb
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  axi_word_t           r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_stb;

  // The ID slot also clears in reset so the flat register output reads zero until reset is released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_wr_stb <= '0;
    end else begin
      r_wr_stb       <= '0;
      r_regs[ID_IDX] <= ID_VALUE;
      if (i_we && (i_widx != ID_IDX)) begin
        r_regs[i_widx] <= strb_merge(r_regs[i_widx], i_wdata, i_wstrb);
        if (|i_wstrb) r_wr_stb[i_widx] <= 1'b1;
      end
    end
  end

  assign o_rdata  = (i_ridx == ID_IDX) ? ID_VALUE : r_regs[i_ridx];
  assign o_wr_stb = r_wr_stb;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[32*g +: 32] = r_regs[g];
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-lite register slave: independent write (AW+W -> B) and read (AR -> R) FSMs over a register bank.
// Writes respond 1 cycle after both AW and W are held and reads respond 1 cycle after AR; B and R hold until ready.
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter axi_word_t   BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_REGS  = 16,
  parameter axi_word_t   ID_VALUE  = 32'hA41C_0001
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  input  logic [31:0]            s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [31:0]            s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    reg_wr_stb
);

  localparam int unsigned      IDX_W  = $clog2(NUM_REGS);
  localparam axi_word_t        SPAN   = axi_word_t'(NUM_REGS * 4);
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  wr_state_t        r_wstate, w_wstate_nxt;
  rd_state_t        r_rstate, w_rstate_nxt;
  logic             r_live;
  logic             r_aw_held, r_w_held;
  axi_word_t        r_awaddr, r_wdata;
  logic [3:0]       r_wstrb;
  axi_resp_t        r_bresp, r_rresp;
  axi_word_t        r_rdata;

  logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  axi_word_t        w_aw_off, w_ar_off, w_core_rdata;
  logic             w_aw_in, w_ar_in, w_aw_wr_ok;
  logic [IDX_W-1:0] w_aw_idx, w_ar_idx;

  // addr[1:0] drops out in the shift; range is checked on the full offset so wrap-around is SLVERR.
  assign w_aw_off   = r_awaddr - BASE_ADDR;
  assign w_aw_in    = w_aw_off < SPAN;
  assign w_aw_idx   = IDX_W'(w_aw_off >> 2);
  assign w_aw_wr_ok = w_aw_in && (w_aw_idx != ID_IDX);
  assign w_ar_off   = s_axi_araddr - BASE_ADDR;
  assign w_ar_in    = w_ar_off < SPAN;
  assign w_ar_idx   = IDX_W'(w_ar_off >> 2);

  // r_live keeps every ready low through reset and for the first edge after it.
  assign s_axi_awready = r_live && !r_aw_held && (r_wstate == W_IDLE);
  assign s_axi_wready  = r_live && !r_w_held  && (r_wstate == W_IDLE);
  assign s_axi_arready = r_live && (r_rstate == R_IDLE);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: if (r_aw_held && r_w_held) begin
        w_commit     = 1'b1;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: if (s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_live <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_aw_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi_wdata;
          r_wstrb  <= s_axi_wstrb;
        end
      end
      // Sampled before the same-edge write lands, so a colliding read sees the old value.
      if (w_ar_hs) begin
        r_rdata <= w_ar_in ? w_core_rdata : '0;
        r_rresp <= w_ar_in ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axi4lite_regfile_core #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_core (
    .i_clk    (s_axi_aclk),
    .i_rst    (s_axi_areset),
    .i_we     (w_commit && w_aw_wr_ok),
    .i_widx   (w_aw_idx),
    .i_wdata  (r_wdata),
    .i_wstrb  (r_wstrb),
    .i_ridx   (w_ar_idx),
    .o_rdata  (w_core_rdata),
    .o_regs   (reg_out),
    .o_wr_stb (reg_wr_stb)
  );

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: handshakes, strobes, decode errors, backpressure and reset abort.
module tb_axi4lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr_stb;

  int tests = 0;
  int fails = 0;
  int stb_cnt [16];
  int stb_snap [16];

  always #5 clk = ~clk;

  axi4lite_reg_slave dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
  );

  initial for (int k = 0; k < 16; k++) stb_cnt[k] = 0;
  always @(negedge clk) for (int k = 0; k < 16; k++) if (reg_wr_stb[k] === 1'b1) stb_cnt[k]++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_acc, w_acc, got = 0;
    resp = 2'bxx;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      tick();
      if (aw_acc) begin awvalid = 0; aw_done = 1; end
      if (w_acc)  begin wvalid = 0;  w_done = 1;  end
    end
    for (int c = 0; c < 20 && !got && aw_done && w_done; c++) begin
      if (bvalid) begin resp = bresp; got = 1; end
      tick();
    end
    awvalid = 0; wvalid = 0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL write_timeout addr=%h aw_done=%0d w_done=%0d bvalid_seen=0 required=1", a, aw_done, w_done);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit acc_done = 0, got = 0, acc;
    d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1; rready = 1;
    for (int c = 0; c < 20 && !acc_done; c++) begin
      acc = arready;
      tick();
      if (acc) begin arvalid = 0; acc_done = 1; end
    end
    for (int c = 0; c < 20 && !got && acc_done; c++) begin
      if (rvalid) begin d = rdata; resp = rresp; got = 1; end
      tick();
    end
    arvalid = 0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL read_timeout addr=%h ar_done=%0d rvalid_seen=0 required=1", a, acc_done);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    tests++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin fails++;
      $display("FAIL reset_ctrl got=%b required=00000", {awready, wready, arready, bvalid, rvalid}); end
    tests++; if (reg_out !== '0 || reg_wr_stb !== '0) begin fails++;
      $display("FAIL reset_regs got=%h stb=%h required=0", reg_out, reg_wr_stb); end
    tests++; if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin fails++;
      $display("FAIL reset_data rdata=%h bresp=%b rresp=%b required=0", rdata, bresp, rresp); end
    rst = 0;
    tests++; if (awready !== 1'b0) begin fails++;
      $display("FAIL reset_release_early awready=%b required=0", awready); end
    tick();
    tests++; if ({awready, wready, arready} !== 3'b111) begin fails++;
      $display("FAIL reset_release_ready got=%b required=111", {awready, wready, arready}); end
  endtask

  task automatic test_basic_rw();
    logic [1:0] r; logic [31:0] d; int tot;
    stb_snap = stb_cnt;
    axi_write(32'h8, 32'h1234_5678, 4'hF, r);
    tests++; if (r !== 2'b00) begin fails++; $display("FAIL basic_bresp got=%b required=00", r); end
    tot = 0; for (int k = 0; k < 16; k++) tot += stb_cnt[k] - stb_snap[k];
    tests++; if (stb_cnt[2] - stb_snap[2] != 1 || tot != 1) begin fails++;
      $display("FAIL basic_stb got_idx2=%0d total=%0d required=1", stb_cnt[2] - stb_snap[2], tot); end
    tests++; if (reg_out[64 +: 32] !== 32'h1234_5678) begin fails++;
      $display("FAIL basic_reg_out got=%h required=12345678", reg_out[64 +: 32]); end
    axi_read(32'h8, d, r);
    tests++; if (d !== 32'h1234_5678 || r !== 2'b00) begin fails++;
      $display("FAIL basic_read got=%h/%b required=12345678/00", d, r); end
  endtask

  task automatic test_order();
    int bcnt = 0;
    bready = 1;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    tick(); wvalid = 0;
    tests++; if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin fails++;
      $display("FAIL order_w_held wready=%b awready=%b bvalid=%b required=0/1/0", wready, awready, bvalid); end
    tick();
    awaddr = 32'h14; awvalid = 1;
    tick(); awvalid = 0;
    tests++; if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0) begin fails++;
      $display("FAIL order_both_held awready=%b wready=%b bvalid=%b required=0/0/0", awready, wready, bvalid); end
    for (int c = 0; c < 6; c++) begin tick(); if (bvalid) bcnt++; end
    tests++; if (bcnt != 1 || reg_out[160 +: 32] !== 32'h0BAD_F00D) begin fails++;
      $display("FAIL order_w_first bvalid_cycles=%0d reg5=%h required=1/0badf00d", bcnt, reg_out[160 +: 32]); end
    bcnt = 0;
    awaddr = 32'h18; awvalid = 1; wdata = 32'h600D_CAFE; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tests++; if (awready !== 1'b0 || wready !== 1'b0) begin fails++;
      $display("FAIL same_cycle_held awready=%b wready=%b required=0/0", awready, wready); end
    for (int c = 0; c < 6; c++) begin tick(); if (bvalid) bcnt++; end
    tests++; if (bcnt != 1 || reg_out[192 +: 32] !== 32'h600D_CAFE) begin fails++;
      $display("FAIL same_cycle bvalid_cycles=%0d reg6=%h required=1/600dcafe", bcnt, reg_out[192 +: 32]); end
  endtask

  task automatic test_strobes();
    logic [1:0] r; logic [31:0] d;
    axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(32'hC, 32'h0000_00AB, 4'b0001, r);
    axi_read(32'hC, d, r);
    tests++; if (d !== 32'hFFFF_FFAB) begin fails++; $display("FAIL strb_byte0 got=%h required=ffffffab", d); end
    stb_snap = stb_cnt;
    axi_write(32'hC, 32'h0, 4'h0, r);
    tests++; if (r !== 2'b00 || stb_cnt[3] != stb_snap[3] || reg_out[96 +: 32] !== 32'hFFFF_FFAB) begin fails++;
      $display("FAIL strb_zero bresp=%b stb=%0d reg3=%h required=00/0/ffffffab", r, stb_cnt[3] - stb_snap[3], reg_out[96 +: 32]); end
    axi_write(32'hC, 32'h1122_3344, 4'b1010, r);
    axi_read(32'hC, d, r);
    tests++; if (d !== 32'h11FF_33AB) begin fails++; $display("FAIL strb_1010 got=%h required=11ff33ab", d); end
  endtask

  task automatic test_decode();
    logic [1:0] r; logic [31:0] d; int tot;
    axi_read(32'h40, d, r);
    tests++; if (d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL oor_read got=%h/%b required=0/10", d, r); end
    axi_read(32'hFFFF_FFF0, d, r);
    tests++; if (d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL wrap_read got=%h/%b required=0/10", d, r); end
    stb_snap = stb_cnt;
    axi_write(32'h3C, 32'hDEAD_BEEF, 4'hF, r);
    tot = 0; for (int k = 0; k < 16; k++) tot += stb_cnt[k] - stb_snap[k];
    tests++; if (r !== 2'b10 || tot != 0) begin fails++; $display("FAIL id_write bresp=%b stb=%0d required=10/0", r, tot); end
    axi_write(32'h44, 32'hDEAD_BEEF, 4'hF, r);
    tests++; if (r !== 2'b10) begin fails++; $display("FAIL oor_write bresp=%b required=10", r); end
    axi_read(32'h3C, d, r);
    tests++; if (d !== 32'hA41C_0001 || r !== 2'b00 || reg_out[480 +: 32] !== 32'hA41C_0001) begin fails++;
      $display("FAIL id_read got=%h/%b reg15=%h required=a41c0001/00", d, r, reg_out[480 +: 32]); end
    axi_read(32'h1B, d, r);
    tests++; if (d !== 32'h600D_CAFE || r !== 2'b00) begin fails++;
      $display("FAIL unaligned_read got=%h/%b required=600dcafe/00", d, r); end
  endtask

  task automatic test_collision();
    bready = 1; rready = 1;
    awaddr = 32'h8; wdata = 32'hCAFE_BABE; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    araddr = 32'h8; arvalid = 1;
    tick(); arvalid = 0;
    tests++; if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || bvalid !== 1'b1 || reg_out[64 +: 32] !== 32'hCAFE_BABE) begin fails++;
      $display("FAIL collision rvalid=%b rdata=%h bvalid=%b reg2=%h required=1/12345678/1/cafebabe", rvalid, rdata, bvalid, reg_out[64 +: 32]); end
    tick();
    tests++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin fails++;
      $display("FAIL collision_done rvalid=%b bvalid=%b required=0/0", rvalid, bvalid); end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    rready = 0; araddr = 32'h8; arvalid = 1;
    tick(); arvalid = 0;
    for (int c = 0; c < 5; c++) begin
      tests++; if (rvalid !== 1'b1 || rdata !== 32'hCAFE_BABE || rresp !== 2'b00 || arready !== 1'b0) begin fails++;
        $display("FAIL r_hold c=%0d rvalid=%b rdata=%h rresp=%b arready=%b required=1/cafebabe/00/0", c, rvalid, rdata, rresp, arready); end
      tick();
    end
    rready = 1; tick();
    tests++; if (rvalid !== 1'b0 || arready !== 1'b1) begin fails++;
      $display("FAIL r_release rvalid=%b arready=%b required=0/1", rvalid, arready); end
    bready = 0; awaddr = 32'h10; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    for (int c = 0; c < 4 && !seen; c++) begin tick(); seen = bvalid; end
    for (int c = 0; c < 5; c++) begin
      tests++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin fails++;
        $display("FAIL b_hold c=%0d bvalid=%b bresp=%b awready=%b wready=%b required=1/00/0/0", c, bvalid, bresp, awready, wready); end
      tick();
    end
    bready = 1; tick();
    tests++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin fails++;
      $display("FAIL b_release bvalid=%b awready=%b wready=%b required=0/1/1", bvalid, awready, wready); end
  endtask

  task automatic test_reset_abort();
    int bcnt = 0;
    bready = 1;
    awaddr = 32'h1C; awvalid = 1;
    tick(); awvalid = 0;
    rst = 1;
    tick();
    tests++; if (awready !== 1'b0 || bvalid !== 1'b0 || reg_out !== '0) begin fails++;
      $display("FAIL abort_in_reset awready=%b bvalid=%b regs_zero=%b required=0/0/1", awready, bvalid, reg_out == '0); end
    tick(); rst = 0;
    tests++; if (awready !== 1'b0) begin fails++; $display("FAIL abort_release_early awready=%b required=0", awready); end
    tick();
    tests++; if (awready !== 1'b1) begin fails++; $display("FAIL abort_release awready=%b required=1", awready); end
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
    tick(); wvalid = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (bvalid) bcnt++; end
    tests++; if (bcnt != 0) begin fails++; $display("FAIL abort_no_bresp bvalid_cycles=%0d required=0", bcnt); end
    awaddr = 32'h1C; awvalid = 1;
    tick(); awvalid = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (bvalid) bcnt++; end
    tests++; if (bcnt != 1 || reg_out[224 +: 32] !== 32'h77) begin fails++;
      $display("FAIL abort_recover bvalid_cycles=%0d reg7=%h required=1/00000077", bcnt, reg_out[224 +: 32]); end
  endtask

  initial begin
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 1; araddr = 0; arvalid = 0; rready = 1;
    test_reset();
    test_basic_rw();
    test_order();
    test_strobes();
    test_decode();
    test_collision();
    test_backpressure();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
